// File: rtl/uart_block_loader_if.sv
// Host-side bundle of the UART block loader: serial input, SHA handshake and status.
// The master modport is the loader itself; the slave modport is whoever drives the line and watches the block.
interface uart_block_loader_if #(
   parameter int BLOCK_BYTES = 64
) ();
   localparam int BLOCK_BITS = BLOCK_BYTES * 8;
   localparam int CNT_W      = $clog2(BLOCK_BYTES + 1);

   logic                  i_uart_rx;
   logic                  i_hash_done;
   logic [BLOCK_BITS-1:0] o_data;
   logic                  o_sha_start;
   logic                  o_busy;
   logic [CNT_W-1:0]      o_byte_cnt;
   logic                  o_frame_err;
   logic                  o_overrun;

   modport master (
      input  i_uart_rx,
      input  i_hash_done,
      output o_data,
      output o_sha_start,
      output o_busy,
      output o_byte_cnt,
      output o_frame_err,
      output o_overrun
   );

   modport slave (
      output i_uart_rx,
      output i_hash_done,
      input  o_data,
      input  o_sha_start,
      input  o_busy,
      input  o_byte_cnt,
      input  o_frame_err,
      input  o_overrun
   );
endinterface

// File: rtl/uart_block_loader.sv
// 8N1 UART receiver feeding a byte packer that hands complete 512-bit blocks to a SHA-256 core
// and refuses new input until the core signals completion.
module uart_block_loader #(
   parameter int CLKS_PER_BIT      = 87,
   parameter int BLOCK_BYTES       = 64,
   parameter int IDLE_TIMEOUT_BITS = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_block_loader_if.master  bus
);
   localparam int BLOCK_BITS = BLOCK_BYTES * 8;
   localparam int CNT_W      = $clog2(BLOCK_BYTES + 1);
   localparam int CPB_W      = $clog2(CLKS_PER_BIT);
   localparam int TIMEOUT    = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int SIL_W      = $clog2(TIMEOUT);

   localparam logic [CPB_W-1:0] BIT_LAST  = CPB_W'(CLKS_PER_BIT - 1);
   localparam logic [CPB_W-1:0] HALF_BIT  = CPB_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BLOCK_BYTES - 1);
   localparam logic [SIL_W-1:0] SIL_LAST  = SIL_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
   typedef enum logic {A_FILL, A_WAIT} asm_state_t;

   // ---------------------------------------------------------------- input synchroniser
   logic rx_meta, rx_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= bus.i_uart_rx;
         rx_sync <= rx_meta;
      end
   end

   // ---------------------------------------------------------------- UART receiver
   rx_state_t        rx_state, rx_state_n;
   logic [CPB_W-1:0] clk_cnt, clk_cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       rx_byte, rx_byte_n;
   logic             rx_valid, rx_valid_n;
   logic             frame_err_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state        <= R_IDLE;
         clk_cnt         <= '0;
         bit_idx         <= '0;
         rx_byte         <= '0;
         rx_valid        <= 1'b0;
         bus.o_frame_err <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         rx_state        <= rx_state_n;
         clk_cnt         <= clk_cnt_n;
         bit_idx         <= bit_idx_n;
         rx_byte         <= rx_byte_n;
         rx_valid        <= rx_valid_n;
         bus.o_frame_err <= frame_err_n;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, otherwise unassigned paths infer latches.
      rx_state_n  = rx_state;
      clk_cnt_n   = clk_cnt;
      bit_idx_n   = bit_idx;
      rx_byte_n   = rx_byte;
      rx_valid_n  = 1'b0;
      frame_err_n = 1'b0;
      unique case (rx_state)
         R_IDLE: begin
            if (!rx_sync) begin
               rx_state_n = R_START;
               clk_cnt_n  = '0;
            end
         end
         R_START: begin
            if (clk_cnt == HALF_BIT) begin
               clk_cnt_n = '0;
               bit_idx_n = '0;
               // A start bit that has gone high again by mid-bit was only a glitch.
               rx_state_n = rx_sync ? R_IDLE : R_DATA;
            end else begin
               clk_cnt_n = clk_cnt + 1'b1;
            end
         end
         R_DATA: begin
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_n = '0;
               rx_byte_n = {rx_sync, rx_byte[7:1]};
               if (bit_idx == 3'd7) rx_state_n = R_STOP;
               else                 bit_idx_n  = bit_idx + 1'b1;
            end else begin
               clk_cnt_n = clk_cnt + 1'b1;
            end
         end
         R_STOP: begin
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_n = '0;
               if (rx_sync) begin
                  rx_valid_n = 1'b1;
                  rx_state_n = R_IDLE;
               end else begin
                  frame_err_n = 1'b1;
                  rx_state_n  = R_BREAK;
               end
            end else begin
               clk_cnt_n = clk_cnt + 1'b1;
            end
         end
         R_BREAK: begin
            if (rx_sync) rx_state_n = R_IDLE;
         end
         default: rx_state_n = R_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- block assembler
   asm_state_t            a_state, a_state_n;
   logic [BLOCK_BITS-1:0] buffer;
   logic [BLOCK_BITS-1:0] shifted;
   logic [SIL_W-1:0]      silence;
   logic                  hash_done_q;
   logic                  hash_rise;
   logic                  accept, complete, drop, release_busy, timeout_hit;

   assign shifted   = {buffer[BLOCK_BITS-9:0], rx_byte};
   assign hash_rise = bus.i_hash_done & ~hash_done_q;

   // Silence only accumulates while a partial block sits idle with the receiver waiting for a start bit.
   assign timeout_hit = (a_state == A_FILL) && (bus.o_byte_cnt != '0) && !rx_valid &&
                        (rx_state == R_IDLE) && (silence == SIL_LAST);

   always_comb begin
      a_state_n    = a_state;
      accept       = 1'b0;
      complete     = 1'b0;
      drop         = 1'b0;
      release_busy = 1'b0;
      unique case (a_state)
         A_FILL: begin
            if (rx_valid) begin
               accept = 1'b1;
               if (bus.o_byte_cnt == BYTE_LAST) begin
                  complete  = 1'b1;
                  a_state_n = A_WAIT;
               end
            end
         end
         A_WAIT: begin
            drop = rx_valid;
            if (hash_rise) begin
               release_busy = 1'b1;
               a_state_n    = A_FILL;
            end
         end
         default: a_state_n = A_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         silence <= '0;
      end else if ((a_state != A_FILL) || (bus.o_byte_cnt == '0) || rx_valid ||
                   (rx_state != R_IDLE) || timeout_hit) begin
         silence <= '0;
      end else begin
         silence <= silence + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_state         <= A_FILL;
         // NOTE: the block buffer is reset along with control state so a reset mid-block leaves no stale bytes.
         buffer          <= '0;
         bus.o_data      <= '0;
         bus.o_byte_cnt  <= '0;
         bus.o_sha_start <= 1'b0;
         bus.o_busy      <= 1'b0;
         bus.o_overrun   <= 1'b0;
         hash_done_q     <= 1'b0;
      end else begin
         a_state         <= a_state_n;
         hash_done_q     <= bus.i_hash_done;
         bus.o_sha_start <= complete;
         bus.o_overrun   <= drop;
         if (accept) begin
            buffer <= shifted;
            if (complete) begin
               bus.o_data     <= shifted;
               bus.o_byte_cnt <= '0;
               bus.o_busy     <= 1'b1;
            end else begin
               bus.o_byte_cnt <= bus.o_byte_cnt + 1'b1;
            end
         end else if (timeout_hit) begin
            buffer         <= '0;
            bus.o_byte_cnt <= '0;
         end
         if (release_busy) bus.o_busy <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_block_loader.sv
// Directed bench for uart_block_loader: block assembly, framing errors, idle timeout,
// overrun while busy, hash_done edge handling and reset mid-block.
module tb_uart_block_loader;
   localparam int CPB = 8;

   localparam logic [511:0] BLK_INC = 512'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f_202122232425262728292a2b2c2d2e2f_303132333435363738393a3b3c3d3e3f;
   localparam logic [511:0] BLK_40  = 512'h404142434445464748494a4b4c4d4e4f_505152535455565758595a5b5c5d5e5f_606162636465666768696a6b6c6d6e6f_707172737475767778797a7b7c7d7e7f;

   logic clk = 1'b0;
   logic rst;

   int checks = 0;
   int errors = 0;
   int sha_cnt = 0;
   int start_long = 0;
   int ferr_cnt = 0;
   int ovr_cnt = 0;
   logic start_prev = 1'b0;

   uart_block_loader_if #(.BLOCK_BYTES(64)) bus ();

   uart_block_loader #(
      .CLKS_PER_BIT      (CPB),
      .BLOCK_BYTES       (64),
      .IDLE_TIMEOUT_BITS (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.o_sha_start) begin
         sha_cnt <= sha_cnt + 1;
         if (start_prev) start_long <= start_long + 1;
      end
      start_prev <= bus.o_sha_start;
      if (bus.o_frame_err) ferr_cnt <= ferr_cnt + 1;
      if (bus.o_overrun)   ovr_cnt  <= ovr_cnt + 1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      bus.i_uart_rx = 1'b0;
      idle_clks(CPB);
      for (int i = 0; i < 8; i++) begin
         bus.i_uart_rx = b[i];
         idle_clks(CPB);
      end
      bus.i_uart_rx = stop_bit;
      idle_clks(CPB);
      bus.i_uart_rx = 1'b1;
      idle_clks(CPB);
   endtask

   task automatic wait_sha(input string tag, input int n);
      int k = 0;
      while (sha_cnt < n && k < 400) begin
         @(negedge clk);
         k++;
      end
      idle_clks(2);
      check(tag, sha_cnt, n);
   endtask

   initial begin
      rst             = 1'b1;
      bus.i_uart_rx   = 1'b1;
      bus.i_hash_done = 1'b0;
      idle_clks(4);
      check("rst_data",  bus.o_data, '0);
      check("rst_busy",  bus.o_busy, 0);
      check("rst_cnt",   bus.o_byte_cnt, 0);
      check("rst_start", bus.o_sha_start, 0);
      check("rst_ferr",  bus.o_frame_err, 0);
      check("rst_ovr",   bus.o_overrun, 0);
      rst = 1'b0;
      idle_clks(4);

      // Block of 0x00..0x3F
      for (int i = 0; i < 64; i++) begin
         send_byte(8'(i), 1'b1);
         if (i == 30) check("t1_cnt31", bus.o_byte_cnt, 31);
      end
      wait_sha("t1_one_start", 1);
      check("t1_data", bus.o_data, BLK_INC);
      check("t1_busy", bus.o_busy, 1);
      check("t1_cnt",  bus.o_byte_cnt, 0);

      // Byte while busy is dropped
      send_byte(8'h11, 1'b1);
      check("t4_ovr",   ovr_cnt, 1);
      check("t4_nostart", sha_cnt, 1);
      check("t4_cnt",   bus.o_byte_cnt, 0);
      check("t4_busy",  bus.o_busy, 1);
      bus.i_hash_done = 1'b1;
      @(negedge clk);
      bus.i_hash_done = 1'b0;
      @(negedge clk);
      check("t4_release", bus.o_busy, 0);
      check("t4_data_hold", bus.o_data, BLK_INC);

      // Framing error then good byte
      send_byte(8'hA5, 1'b0);
      check("t2_ferr", ferr_cnt, 1);
      check("t2_cnt0", bus.o_byte_cnt, 0);
      send_byte(8'h5A, 1'b1);
      check("t2_cnt1", bus.o_byte_cnt, 1);

      // Idle timeout discards a 10-byte partial block
      for (int i = 0; i < 9; i++) send_byte(8'hE0 + 8'(i), 1'b1);
      check("t3_cnt10", bus.o_byte_cnt, 10);
      check("t3_data_hold", bus.o_data, BLK_INC);
      idle_clks(10 * CPB);
      check("t3_pre_timeout", bus.o_byte_cnt, 10);
      idle_clks(10 * CPB);
      check("t3_timeout", bus.o_byte_cnt, 0);
      for (int i = 0; i < 64; i++) send_byte(8'hFF, 1'b1);
      wait_sha("t3_start", 2);
      check("t3_data", bus.o_data, {512{1'b1}});
      check("t3_single", start_long, 0);

      // Held-high hash_done: first rise releases, stale level must not release the next block
      bus.i_hash_done = 1'b1;
      idle_clks(2);
      check("t5_release", bus.o_busy, 0);
      send_byte(8'h5A, 1'b1);
      send_byte(8'h5A, 1'b1);
      bus.i_uart_rx = 1'b0;
      idle_clks(2);
      bus.i_uart_rx = 1'b1;
      idle_clks(2 * CPB);
      check("t5_glitch_cnt",  bus.o_byte_cnt, 2);
      check("t5_glitch_ferr", ferr_cnt, 1);
      for (int i = 0; i < 62; i++) send_byte(8'h5A, 1'b1);
      wait_sha("t5_start", 3);
      check("t5_data", bus.o_data, {64{8'h5A}});
      idle_clks(20);
      check("t5_stale_busy", bus.o_busy, 1);
      bus.i_hash_done = 1'b0;
      idle_clks(10);
      check("t5_fall_busy", bus.o_busy, 1);
      bus.i_hash_done = 1'b1;
      idle_clks(2);
      check("t5_rise_release", bus.o_busy, 0);
      bus.i_hash_done = 1'b0;

      // Reset in the middle of the 30th byte
      for (int i = 0; i < 29; i++) send_byte(8'h77, 1'b1);
      check("t6_cnt29", bus.o_byte_cnt, 29);
      bus.i_uart_rx = 1'b0;
      idle_clks(CPB);
      bus.i_uart_rx = 1'b1;
      idle_clks(3 * CPB + CPB / 2);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_data",  bus.o_data, '0);
      check("t6_rst_cnt",   bus.o_byte_cnt, 0);
      check("t6_rst_busy",  bus.o_busy, 0);
      check("t6_rst_start", bus.o_sha_start, 0);
      rst = 1'b0;
      idle_clks(2 * CPB);
      check("t6_post_cnt", bus.o_byte_cnt, 0);
      for (int i = 0; i < 64; i++) send_byte(8'h40 + 8'(i), 1'b1);
      wait_sha("t6_start", 4);
      check("t6_data", bus.o_data, BLK_40);
      check("t6_busy", bus.o_busy, 1);
      check("final_single", start_long, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
